// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD voice arbiter slice: arbiter state encoding,
// card address width and default block / timeout sizes.
// ---------------------------------------------------------------------------
package sd_pkg;

    localparam int SD_ADDR_W      = 32;
    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_TIMEOUT     = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        XFER,
        FINISH
    } sd_state_t;

endpackage

// File: rtl/sd_voice_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector. Scans req starting at ptr
// and wrapping modulo N; the first set bit wins.
//   req    : request vector
//   ptr    : index with highest priority this cycle (must be < N)
//   winner : one-hot winning request (zero when none)
//   idx    : binary index of the winner (zero when none)
//   any    : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        j      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + int'(i)) % N);
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = j;
                winner[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_voice_arbiter.sv
// ---------------------------------------------------------------------------
// sd_voice_arbiter
// Shares one SDctrl block-read engine between NUM_VOICES requesters. A
// requester is chosen round-robin, its address is latched and issued with a
// one-cycle sd_en, and the returned bytes are forwarded to that voice only.
// Completion (done) or abort (err: short block / engine never went busy)
// is pulsed per voice.
//   clk, rst      : system clock, asynchronous active-high reset
//   req           : per-voice level request, held until done/err
//   req_addr      : per-voice card address, voice i at [32i+31:32i]
//   grant         : one-hot owner of the engine, zero when idle
//   done, err     : one-cycle per-voice completion / abort pulses
//   rd_data       : forwarded data byte (registered)
//   rd_valid      : per-voice byte strobe, at most one bit high
//   sd_address    : latched address presented to SDctrl
//   sd_en         : one-cycle start pulse to SDctrl
//   sd_rdy        : SDctrl idle; its fall marks the read in progress
//   sd_data       : byte from SDctrl
//   sd_data_valid : byte strobe from SDctrl
//   busy          : arbiter is not in IDLE
// ---------------------------------------------------------------------------
module sd_voice_arbiter
    import sd_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int TIMEOUT     = SD_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_VOICES-1:0]           req,
    input  logic [NUM_VOICES*SD_ADDR_W-1:0] req_addr,
    output logic [NUM_VOICES-1:0]           grant,
    output logic [NUM_VOICES-1:0]           done,
    output logic [NUM_VOICES-1:0]           err,
    output logic [7:0]                      rd_data,
    output logic [NUM_VOICES-1:0]           rd_valid,
    output logic [SD_ADDR_W-1:0]            sd_address,
    output logic                            sd_en,
    input  logic                            sd_rdy,
    input  logic [7:0]                      sd_data,
    input  logic                            sd_data_valid,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] BLOCK_C = CW'(BLOCK_BYTES);
    localparam logic [TW-1:0] TLIMIT  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_V  = IW'(NUM_VOICES - 1);

    sd_state_t state, state_nxt;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         idx_q;
    logic [SD_ADDR_W-1:0]  addr_q;
    logic [CW-1:0]         count;
    logic [TW-1:0]         tcnt;

    logic [NUM_VOICES-1:0] pick_onehot;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;

    logic                  accept;
    logic [CW-1:0]         count_after;

    rr_pick #(
        .N  (NUM_VOICES),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // A byte arriving together with sd_rdy rising still counts toward the
    // done/err decision taken in that same cycle.
    assign accept      = (state == XFER) && sd_data_valid && (count < BLOCK_C);
    assign count_after = count + CW'(accept);

    assign sd_address  = addr_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (sd_rdy && pick_any) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!sd_rdy) begin
                    state_nxt = XFER;
                end else if (tcnt == TLIMIT) begin
                    state_nxt = FINISH;
                end
            end
            XFER:      if (sd_rdy) state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        sd_en = (state == ISSUE);
        busy  = (state != IDLE);
    end

    // Datapath: selection latch, counters, routed data and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            done     <= '0;
            err      <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
            rr_ptr   <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            count    <= '0;
            tcnt     <= '0;
        end else begin
            done     <= '0;
            err      <= '0;
            rd_valid <= '0;
            case (state)
                IDLE: begin
                    if (sd_rdy && pick_any) begin
                        idx_q  <= pick_idx;
                        addr_q <= req_addr[pick_idx*SD_ADDR_W +: SD_ADDR_W];
                        grant  <= pick_onehot;
                    end
                end
                ISSUE: begin
                    tcnt <= '0;
                end
                WAIT_BUSY: begin
                    if (sd_rdy) begin
                        if (tcnt == TLIMIT) begin
                            err[idx_q] <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (accept) begin
                        rd_data         <= sd_data;
                        rd_valid[idx_q] <= 1'b1;
                        count           <= count_after;
                    end
                    if (sd_rdy) begin
                        if (count_after == BLOCK_C) begin
                            done[idx_q] <= 1'b1;
                        end else begin
                            err[idx_q] <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    grant  <= '0;
                    count  <= '0;
                    rr_ptr <= (idx_q == LAST_V) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_voice_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_voice_arbiter
// Directed bench for sd_voice_arbiter with a behavioural SDctrl model.
// Stimulus pushes expected addresses, grants, bytes and done/err events into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sd_voice_arbiter;

    localparam int NV = 4;
    localparam int BB = 512;
    localparam int TO = 64;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_EDGE   = 2;

    logic            clk;
    logic            rst;
    logic [NV-1:0]   req;
    logic [NV*32-1:0] req_addr;
    logic [NV-1:0]   grant;
    logic [NV-1:0]   done;
    logic [NV-1:0]   err;
    logic [7:0]      rd_data;
    logic [NV-1:0]   rd_valid;
    logic [31:0]     sd_address;
    logic            sd_en;
    logic            sd_rdy;
    logic [7:0]      sd_data;
    logic            sd_data_valid;
    logic            busy;

    sd_voice_arbiter #(
        .NUM_VOICES  (NV),
        .BLOCK_BYTES (BB),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_addr      (req_addr),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .sd_address    (sd_address),
        .sd_en         (sd_en),
        .sd_rdy        (sd_rdy),
        .sd_data       (sd_data),
        .sd_data_valid (sd_data_valid),
        .busy          (busy)
    );

    typedef struct { int voice; logic [7:0] data; } byte_exp_t;
    typedef struct { int voice; bit is_err; }       evt_exp_t;
    typedef struct { int nbytes; int mode; }        mdl_cfg_t;

    byte_exp_t     exp_bytes[$];
    evt_exp_t      exp_evts[$];
    logic [31:0]   exp_addr[$];
    logic [NV-1:0] exp_grant[$];
    mdl_cfg_t      mdl_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sd_en_cyc = 0;
    int last_rv_cyc = 0;
    int evt_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected output expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [NV-1:0] prev_grant;
        byte_exp_t     e;
        evt_exp_t      ev;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sd_en) begin
                    sd_en_cyc = cyc;
                    if (exp_addr.size() == 0) fail_unexpected("sd_en");
                    else check("sd_address", sd_address, exp_addr.pop_front());
                end
                if (grant != '0 && prev_grant == '0) begin
                    if (exp_grant.size() == 0) fail_unexpected("grant");
                    else check("grant", 32'(grant), 32'(exp_grant.pop_front()));
                end
                if (rd_valid != '0) begin
                    last_rv_cyc = cyc;
                    if (exp_bytes.size() == 0) begin
                        fail_unexpected("rd_valid");
                    end else begin
                        e = exp_bytes.pop_front();
                        check("rd_valid", 32'(rd_valid), 32'(1) << e.voice);
                        check("rd_data", 32'(rd_data), 32'(e.data));
                    end
                end
                if ((done | err) != '0) begin
                    evt_cyc = cyc;
                    if (exp_evts.size() == 0) begin
                        fail_unexpected("done_err");
                    end else begin
                        ev = exp_evts.pop_front();
                        check("done", 32'(done), ev.is_err ? 32'(0) : 32'(1) << ev.voice);
                        check("err", 32'(err), ev.is_err ? 32'(1) << ev.voice : 32'(0));
                    end
                end
            end
            prev_grant = grant;
        end
    end

    // SDctrl model: rdy drops 3 cycles after sd_en, then one byte per cycle
    initial begin
        mdl_cfg_t cfg;
        bit       aborted;
        sd_rdy        = 1'b1;
        sd_data_valid = 1'b0;
        sd_data       = '0;
        forever begin
            @(negedge clk);
            if (sd_en === 1'b1 && !rst) begin
                if (mdl_q.size() != 0) begin
                    cfg = mdl_q.pop_front();
                end else begin
                    cfg.nbytes = BB;
                    cfg.mode   = M_NORMAL;
                end
                if (cfg.mode != M_NEVER) begin
                    aborted = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    if (rst) aborted = 1'b1;
                    else sd_rdy = 1'b0;
                    for (int b = 0; b < cfg.nbytes && !aborted; b++) begin
                        @(posedge clk);
                        #1;
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            sd_data       = 8'(b);
                            sd_data_valid = 1'b1;
                            if (cfg.mode == M_EDGE && b == cfg.nbytes - 1) sd_rdy = 1'b1;
                        end
                    end
                    @(posedge clk);
                    #1;
                    sd_data_valid = 1'b0;
                    sd_rdy        = 1'b1;
                end
            end
        end
    end

    task automatic set_addr(input int v, input logic [31:0] a);
        req_addr[v*32 +: 32] = a;
    endtask

    task automatic expect_xfer(input int v, input logic [31:0] a, input int nsent,
                               input int mode, input int nexp, input bit with_evt,
                               input bit is_err);
        mdl_cfg_t  c;
        byte_exp_t e;
        evt_exp_t  ev;
        exp_addr.push_back(a);
        exp_grant.push_back(NV'(1) << v);
        c.nbytes = nsent;
        c.mode   = mode;
        mdl_q.push_back(c);
        for (int b = 0; b < nexp; b++) begin
            e.voice = v;
            e.data  = 8'(b);
            exp_bytes.push_back(e);
        end
        if (with_evt) begin
            ev.voice  = v;
            ev.is_err = is_err;
            exp_evts.push_back(ev);
        end
    endtask

    // Waits for n done/err pulses; a requester drops req on its own pulse
    // unless hold is set (then all req drop after the last pulse).
    task automatic wait_events(input int n, input bit hold);
        logic [NV-1:0] seen;
        int            budget;
        for (int k = 0; k < n; k++) begin
            budget = 4000;
            seen   = '0;
            while (seen == '0 && budget > 0) begin
                @(negedge clk);
                #1;
                seen = done | err;
                budget--;
            end
            if (seen == '0) begin
                checks++;
                errors++;
                $display("FAIL event_wait: got no done/err expected a pulse within budget");
                return;
            end
            if (!hold) req = req & ~seen;
            else if (k == n - 1) req = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        #1;
        check("reset_grant", 32'(grant), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_sd_en", 32'(sd_en), 32'(0));
        check("reset_rd_valid", 32'(rd_valid), 32'(0));
        check("reset_done_err", 32'(done | err), 32'(0));
        check("reset_sd_address", sd_address, 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single voice
        set_addr(0, 32'h0000_2000);
        expect_xfer(0, 32'h0000_2000, 512, M_NORMAL, 512, 1'b1, 1'b0);
        req = 4'b0001;
        wait_events(1, 1'b0);
        check("single_done_after_last_byte", 32'(evt_cyc >= last_rv_cyc), 32'(1));
        @(negedge clk);
        #1;
        check("single_grant_released", 32'(grant), 32'(0));
        check("single_busy_cleared", 32'(busy), 32'(0));

        // Round-robin from a fresh pointer: 0,1,2,3,0
        do_reset();
        for (int v = 0; v < NV; v++) set_addr(v, 32'(v + 1) << 12);
        for (int k = 0; k < 5; k++) begin
            expect_xfer(k % NV, 32'((k % NV) + 1) << 12, 512, M_NORMAL, 512, 1'b1, 1'b0);
        end
        req = 4'b1111;
        wait_events(5, 1'b1);

        // Short block on voice 1 (pointer now 1), then voice 2 served
        expect_xfer(1, 32'h0000_2000, 100, M_NORMAL, 100, 1'b1, 1'b1);
        expect_xfer(2, 32'h0000_3000, 512, M_NORMAL, 512, 1'b1, 1'b0);
        req = 4'b0110;
        wait_events(2, 1'b0);

        // Timeout on voice 3: engine never leaves ready
        expect_xfer(3, 32'h0000_4000, 0, M_NEVER, 0, 1'b1, 1'b1);
        req = 4'b1000;
        wait_events(1, 1'b0);
        // WAIT_BUSY is entered the cycle after sd_en
        check("timeout_latency", 32'(evt_cyc - sd_en_cyc), 32'(TO + 1));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("timeout_busy_low", 32'(busy), 32'(0));
        check("timeout_grant_low", 32'(grant), 32'(0));

        // Overrun: 514 bytes sent to voice 0, only 512 forwarded
        expect_xfer(0, 32'h0000_1000, 514, M_NORMAL, 512, 1'b1, 1'b0);
        req = 4'b0001;
        wait_events(1, 1'b0);

        // Edge: 512th byte arrives with sd_rdy rising, on voice 1
        expect_xfer(1, 32'h0000_2000, 512, M_EDGE, 512, 1'b1, 1'b0);
        req = 4'b0010;
        wait_events(1, 1'b0);
        check("edge_done_not_before_last_byte", 32'(evt_cyc >= last_rv_cyc), 32'(1));

        // Async reset at byte 200 of a voice-3 read (pointer now 2)
        expect_xfer(3, 32'h0000_4000, 512, M_NORMAL, 200, 1'b0, 1'b0);
        req    = 4'b1000;
        budget = 2000;
        while (exp_bytes.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check("abort_bytes_reached", 32'(exp_bytes.size()), 32'(0));
        #1;
        rst = 1'b1;
        #1;
        check("abort_grant", 32'(grant), 32'(0));
        check("abort_sd_en", 32'(sd_en), 32'(0));
        check("abort_rd_valid", 32'(rd_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Pointer must be back at 0: with voices 1 and 2 pending, 1 wins first
        expect_xfer(1, 32'h0000_2000, 512, M_NORMAL, 512, 1'b1, 1'b0);
        expect_xfer(2, 32'h0000_3000, 512, M_NORMAL, 512, 1'b1, 1'b0);
        req = 4'b0110;
        wait_events(2, 1'b0);

        repeat (4) @(negedge clk);
        check("leftover_bytes", 32'(exp_bytes.size()), 32'(0));
        check("leftover_events", 32'(exp_evts.size()), 32'(0));
        check("leftover_addresses", 32'(exp_addr.size()), 32'(0));
        check("leftover_grants", 32'(exp_grant.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
